// File: rtl/decoder_3x8_strobe_pkg.sv
// Shared types and widths for the strobed 3-to-8 decoder: FSM state type,
// hold-counter width and one-hot output width.
package decoder_pkg;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned OH_W   = 8;
    localparam int unsigned CODE_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage : decoder_pkg

// File: rtl/decoder_3x8_strobe_if.sv
// Handshake/output bundle of decoder_3x8_strobe; the acc_count signal exists
// only when DECODER_COUNT_EN is defined.
interface decoder_3x8_strobe_if;
    import decoder_pkg::*;

    logic              en;
    logic              in_valid;
    logic [CODE_W-1:0] code;
    logic              in_ready;
    logic [OH_W-1:0]   O;
    logic              out_valid;
    logic              done;
`ifdef DECODER_COUNT_EN
    logic [7:0]        acc_count;

    modport master (
        output en, in_valid, code,
        input  in_ready, O, out_valid, done, acc_count
    );
    modport slave (
        input  en, in_valid, code,
        output in_ready, O, out_valid, done, acc_count
    );
`else
    modport master (
        output en, in_valid, code,
        input  in_ready, O, out_valid, done
    );
    modport slave (
        input  en, in_valid, code,
        output in_ready, O, out_valid, done
    );
`endif

endinterface : decoder_3x8_strobe_if

// File: rtl/decoder_3x8_strobe_dec3to8.sv
// Purely combinational binary-to-one-hot decode of a 3-bit code.
module dec3to8
    import decoder_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output logic [OH_W-1:0]   onehot_o
);

    assign onehot_o = OH_W'(1) << code_i;

endmodule : dec3to8

// File: rtl/decoder_3x8_strobe.sv
// Registered 3-to-8 decoder that holds each one-hot result for HOLD cycles and
// pulses done on the last one. Optional accept counter: DECODER_COUNT_EN.
module decoder_3x8_strobe #(
    parameter int unsigned HOLD = 4
) (
    input  logic               clk,
    input  logic               rst,
    decoder_3x8_strobe_if.slave bus
);
    import decoder_pkg::*;

    // The parameter HOLD shadows the state literal, so states are package-qualified.
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OH_W-1:0]  o_q, o_d;
    logic [OH_W-1:0]  dec_onehot;
    logic             hold_last;
    logic             accept;

    dec3to8 u_dec (
        .code_i   (bus.code),
        .onehot_o (dec_onehot)
    );

    assign hold_last     = (state_q == decoder_pkg::HOLD) && (cnt_q == '0);
    assign bus.in_ready  = !rst && bus.en &&
                           ((state_q == decoder_pkg::IDLE) || hold_last);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.done      = !rst && bus.en && hold_last;
    assign bus.out_valid = (state_q == decoder_pkg::HOLD);
    assign bus.O         = o_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        if (accept) begin
            state_d = decoder_pkg::HOLD;
            cnt_d   = CNT_W'(HOLD - 1);
            o_d     = dec_onehot;
        end else begin
            case (state_q)
                decoder_pkg::IDLE: begin
                    cnt_d = '0;
                    o_d   = '0;
                end
                decoder_pkg::HOLD: begin
                    // Losing enable aborts the hold exactly like running out of cycles.
                    if (!bus.en || (cnt_q == '0)) begin
                        state_d = decoder_pkg::IDLE;
                        cnt_d   = '0;
                        o_d     = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = decoder_pkg::IDLE;
                    cnt_d   = '0;
                    o_d     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= decoder_pkg::IDLE;
            cnt_q   <= '0;
            o_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
        end
    end

`ifdef DECODER_COUNT_EN
    logic [7:0] acc_q, acc_d;

    assign acc_d         = accept ? acc_q + 8'd1 : acc_q;
    assign bus.acc_count = acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`endif

endmodule : decoder_3x8_strobe

// File: doc/decoder_3x8_strobe.md
DECODER_3X8_STROBE -- requirements
Module: decoder_3x8_strobe

Interface
REQ-001 SHALL have parameter HOLD, default 4, giving the number of cycles each decoded one-hot output is held (legal range 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port en  input  1  global enable; low blocks acceptance and aborts output.
REQ-005 SHALL have port in_valid  input  1  code offered this cycle.
REQ-006 SHALL have port code  input  3  binary code to decode, 0..7.
REQ-007 SHALL have port in_ready  output  1  block can accept a code this cycle.
REQ-008 SHALL have port O  output  8  registered one-hot decode, O[code]=1.
REQ-009 SHALL have port out_valid  output  1  O carries a valid decode.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking the final hold cycle.

Function
REQ-011 SHALL implement FSM states IDLE and HOLD, plus a 4-bit hold counter.
REQ-012 SHALL assert in_ready = en && (state==IDLE || (state==HOLD && counter==0)).
REQ-013 SHALL accept a code only when in_valid && in_ready; in_valid while in_ready=0 is ignored and code is not captured.
REQ-014 On acceptance, next cycle: O = 1<<code, out_valid=1, state=HOLD, counter=HOLD-1 (latency 1 cycle).
REQ-015 In HOLD with counter>0 and en=1: O unchanged, counter decrements by 1.
REQ-016 In HOLD with counter==0: done=1 that cycle; next cycle, if a new code is accepted, go to REQ-014 (back-to-back, no gap); otherwise O=0, out_valid=0, state=IDLE.
REQ-017 With HOLD=1: every accepted code produces one output cycle with done=1; in_ready stays 1, giving throughput of 1 code/cycle.
REQ-018 In IDLE: O=0, out_valid=0, done=0.
REQ-019 en low in HOLD: next cycle O=0, out_valid=0, state=IDLE; no done pulse for the aborted code.
REQ-020 out_valid=1 SHALL imply O is exactly one-hot; O SHALL never have more than one bit set.

Reset
REQ-021 rst=1 at a clock edge SHALL force state=IDLE, counter=0, O=8'h00, out_valid=0, done=0, overriding en and in_valid.
REQ-022 Reset mid-HOLD SHALL discard the current code with no done pulse; in_ready SHALL read 0 during rst.

Configuration
REQ-023 Macro DECODER_COUNT_EN defined: adds output port acc_count (8 bits), incremented on every accepted code, wrapping 255->0, cleared by rst.
REQ-024 Macro DECODER_COUNT_EN undefined: acc_count port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-025 Shared package decoder_pkg SHALL hold the FSM state type (IDLE, HOLD), the counter width constant (4), and the one-hot width constant (8).
REQ-026 The combinational 3-to-8 decode SHALL be a sub-module dec3to8 (code in, one-hot out) instantiated once; the sequential logic stays in the top.

Verification
REQ-027 Reset, then en=1, one transfer code=5, HOLD=4 -> O=8'h20 for cycles 1-4 after accept, done=1 on cycle 4, O=0 on cycle 5.
REQ-028 Back-to-back with HOLD=4: codes 2 then 7, second offered continuously -> O=8'h04 for 4 cycles, then O=8'h80 for 4 cycles, no zero gap, done pulses on cycles 4 and 8.
REQ-029 HOLD=1, codes 0..7 on consecutive cycles -> O=01,02,04,...,80 on consecutive cycles, in_ready=1 throughout, done=1 every cycle.
REQ-030 en dropped on hold cycle 2 of code=3 -> next cycle O=0, out_valid=0, no done, in_ready=0 until en returns.
REQ-031 rst asserted on hold cycle 2 of code=6 -> next cycle all outputs 0; with DECODER_COUNT_EN, 300 accepts -> acc_count=44 (wrap check), and 0 after rst.
